// File: rtl/rv32i_types.sv
// ============================================================
// rv32i_types : shared RV32I types plus data-port lane helpers
// Rev 1.0
// ============================================================
`default_nettype none

package rv32i_types;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'd0,
    MAU_BUSY = 2'd1,
    MAU_DONE = 2'd2
  } mau_state_t;

  // Reads always fetch the full word; only stores narrow the lane mask.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3)
      sb:      m = 4'b0001 << a;
      sh:      m = 4'b0011 << {a[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      sb:      w = d << {a, 3'b000};
      sh:      w = d << {a[1], 4'b0000};
      default: w = d;
    endcase
    return w;
  endfunction

  // Misalignment or undefined funct3 for the given direction.
  function automatic logic access_fault(input logic is_read, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic f;
    if (is_read) begin
      case (f3)
        lb, lbu: f = 1'b0;
        lh, lhu: f = a[0];
        lw:      f = (a != 2'b00);
        default: f = 1'b1;
      endcase
    end else begin
      case (f3)
        sb:      f = 1'b0;
        sh:      f = a[0];
        sw:      f = (a != 2'b00);
        default: f = 1'b1;
      endcase
    end
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mau_load_align.sv
// ============================================================
// mau_load_align : byte/halfword select and sign/zero extension
// Rev 1.0
// ============================================================
`default_nettype none

module mau_load_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_sel,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (byte_sel)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = byte_sel[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      lb:      data = {{24{w_byte[7]}}, w_byte};
      lbu:     data = {24'd0, w_byte};
      lh:      data = {{16{w_half[15]}}, w_half};
      lhu:     data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================
// mem_access_unit : MEM-stage load/store sequencer for a data port
// Rev 1.0
// ============================================================
`default_nettype none

module mem_access_unit
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        mem_exc,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  mau_state_t  r_state;
  logic        r_is_read;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic [31:0] r_load;

  logic        w_idle;
  logic        w_busy;
  logic        w_one_dir;
  logic        w_fault;
  logic        w_accept;
  logic [31:0] w_aligned;

  assign w_idle    = (r_state == MAU_IDLE);
  assign w_busy    = (r_state == MAU_BUSY);
  assign w_one_dir = mem_read ^ mem_write;
  assign w_fault   = (mem_read & mem_write)
                   | (w_one_dir & access_fault(mem_read, funct3, addr[1:0]));

  assign mem_exc  = w_idle & req_valid & w_fault;
  assign w_accept = w_idle & req_valid & w_one_dir & ~w_fault;

  // Stall covers the accept cycle so the pipeline freezes before the port is driven.
  assign stall            = w_accept | w_busy;
  assign done             = (r_state == MAU_DONE);
  assign load_data        = done ? r_load : 32'd0;
  assign dmem_read        = w_busy & r_is_read;
  assign dmem_write       = w_busy & ~r_is_read;
  assign dmem_address     = {r_addr[31:2], 2'b00};
  assign dmem_wdata       = r_wdata;
  assign dmem_byte_enable = w_busy ? r_mask : 4'b0000;

  mau_load_align u_align (
    .funct3   (r_funct3),
    .byte_sel (r_addr[1:0]),
    .rdata    (dmem_rdata),
    .data     (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MAU_IDLE;
      r_is_read <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_mask    <= 4'b0000;
      r_load    <= 32'd0;
    end else begin
      case (r_state)
        MAU_IDLE: begin
          if (w_accept) begin
            r_is_read <= mem_read;
            r_funct3  <= funct3;
            r_addr    <= addr;
            r_wdata   <= mem_read ? 32'd0 : store_lanes(funct3, addr[1:0], store_data);
            r_mask    <= mem_read ? 4'b1111 : store_mask(funct3, addr[1:0]);
            r_load    <= 32'd0;
            r_state   <= MAU_BUSY;
          end
        end
        MAU_BUSY: begin
          if (dmem_resp) begin
            r_load  <= r_is_read ? w_aligned : 32'd0;
            r_state <= MAU_DONE;
          end
        end
        MAU_DONE: begin
          r_state <= MAU_IDLE;
        end
        default: begin
          r_state <= MAU_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================
// tb_mem_access_unit : directed vector bench for mem_access_unit
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        mem_exc;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .stall            (stall),
    .done             (done),
    .load_data        (load_data),
    .mem_exc          (mem_exc),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exc;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // One access with dmem_resp in the first BUSY cycle.
  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    drive(v.rd, ~v.rd, v.f3, v.a, v.sdata);
    #1;
    check($sformatf("v%0d mem_exc", i), {31'd0, mem_exc}, {31'd0, v.exc});
    if (v.exc) begin
      check($sformatf("v%0d exc_quiet", i),
            {28'd0, stall, done, dmem_read, dmem_write}, 32'd0);
      tick();
      idle_inputs();
      #1;
      check($sformatf("v%0d exc_no_busy", i), {31'd0, stall | dmem_read | dmem_write}, 32'd0);
    end else begin
      check($sformatf("v%0d accept_stall", i), {31'd0, stall}, 32'd1);
      tick();
      idle_inputs();
      #1;
      check($sformatf("v%0d strobes", i), {30'd0, dmem_read, dmem_write}, {30'd0, v.rd, ~v.rd});
      check($sformatf("v%0d address", i), dmem_address, {v.a[31:2], 2'b00});
      check($sformatf("v%0d mask", i), {28'd0, dmem_byte_enable}, {28'd0, v.mask});
      if (!v.rd) check($sformatf("v%0d wdata", i), dmem_wdata, v.wdata);
      dmem_resp  = 1'b1;
      dmem_rdata = v.rdata;
      tick();
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h5A5A5A5A;
      #1;
      check($sformatf("v%0d done", i), {30'd0, done, stall}, 32'd2);
      if (v.rd) check($sformatf("v%0d load_data", i), load_data, v.load);
      tick();
      check($sformatf("v%0d after_done", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d load_cleared", i), load_data, 32'd0);
    end
  endtask

  initial begin
    int stall_cycles;

    vecs[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1'b0, 4'b1000, 32'hAB00_0000, 32'h0};
    vecs[1]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0000_1234, 32'h0, 1'b0, 4'b1100, 32'h1234_0000, 32'h0};
    vecs[2]  = '{1'b0, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{1'b0, 3'b000, 32'h0000_1001, 32'h0000_00CD, 32'h0, 1'b0, 4'b0010, 32'h0000_CD00, 32'h0};
    vecs[4]  = '{1'b1, 3'b000, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FFF4};
    vecs[5]  = '{1'b1, 3'b100, 32'h0000_2002, 32'h0, 32'h12F4_5678, 1'b0, 4'b1111, 32'h0, 32'h0000_00F4};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h0, 32'hF456_1234, 1'b0, 4'b1111, 32'h0, 32'hFFFF_F456};
    vecs[7]  = '{1'b1, 3'b101, 32'h0000_2002, 32'h0, 32'hF456_1234, 1'b0, 4'b1111, 32'h0, 32'h0000_F456};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D};
    vecs[9]  = '{1'b1, 3'b000, 32'h0000_2001, 32'h0, 32'h0000_80FF, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80};
    vecs[10] = '{1'b1, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_1002, 32'h1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 3'b011, 32'h0000_2000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 3'b100, 32'h0000_1000, 32'h7, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0};

    rst        = 1'b1;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_ctrl", {27'd0, stall, done, mem_exc, dmem_read, dmem_write}, 32'd0);
    check("reset_mask", {28'd0, dmem_byte_enable}, 32'd0);
    check("reset_load", load_data, 32'd0);

    // Response while idle must not produce a completion.
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    check("idle_resp_ignored", {30'd0, done, stall}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i);

    // sb with response in the second BUSY cycle: stall for 3 cycles, done in the 4th.
    stall_cycles = 0;
    drive(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB);
    #1;
    if (stall) stall_cycles++;
    tick();
    idle_inputs();
    #1;
    if (stall) stall_cycles++;
    check("sb2_addr", dmem_address, 32'h0000_1000);
    tick();
    #1;
    if (stall) stall_cycles++;
    check("sb2_held", {27'd0, dmem_write, dmem_byte_enable}, {27'd0, 1'b1, 4'b1000});
    check("sb2_wdata_held", dmem_wdata, 32'hAB00_0000);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    #1;
    check("sb2_stall_cycles", stall_cycles, 32'd3);
    check("sb2_done", {30'd0, done, stall}, 32'd2);
    tick();

    // Request held through DONE must not be re-accepted until IDLE.
    drive(1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0);
    #1;
    check("b2b_accept", {31'd0, stall}, 32'd1);
    tick();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h1111_2222;
    tick();
    dmem_resp  = 1'b0;
    #1;
    check("b2b_done_no_stall", {29'd0, done, stall, dmem_read}, 32'd4);
    check("b2b_load", load_data, 32'h1111_2222);
    tick();
    #1;
    check("b2b_reaccept_idle", {30'd0, done, stall}, 32'd1);
    tick();
    idle_inputs();
    #1;
    check("b2b_second_busy", {31'd0, dmem_read}, 32'd1);
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    tick();

    // Reset in the second BUSY cycle, then a late response.
    drive(1'b1, 1'b0, 3'b010, 32'h0000_2008, 32'h0);
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_busy_quiet", {28'd0, stall, done, dmem_read, dmem_write}, 32'd0);
    tick();
    dmem_resp = 1'b0;
    #1;
    check("rst_late_resp", {30'd0, done, stall}, 32'd0);
    check("rst_late_load", load_data, 32'd0);

    // Both directions at once.
    drive(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0);
    #1;
    check("both_dir_exc", {28'd0, mem_exc, stall, dmem_read, dmem_write}, 32'd8);
    tick();
    idle_inputs();
    #1;
    check("both_dir_no_access", {29'd0, stall, dmem_read, dmem_write}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
